// File: rtl/vga_fb_reader_if.sv
// Framebuffer read port, timing inputs and pixel output of vga_fb_reader.
interface vga_fb_reader_if #(
  parameter int ADDR_W     = 3,
  parameter int RAM_WIDTH  = 32,
  parameter int PIXEL_BITS = 8
);
  logic                  visible;
  logic                  frame_start;
  logic [ADDR_W-1:0]     rd_addr;
  logic                  rd_en;
  logic [RAM_WIDTH-1:0]  rd_data;
  logic [PIXEL_BITS-1:0] pixel;
  logic                  pixel_valid;
  logic                  underrun;

  modport master (
    input  visible, frame_start, rd_data,
    output rd_addr, rd_en, pixel, pixel_valid, underrun
  );
  modport slave (
    output visible, frame_start, rd_data,
    input  rd_addr, rd_en, pixel, pixel_valid, underrun
  );
endinterface

// File: rtl/vga_fb_reader.sv
// Framebuffer-to-VGA pixel streamer: prefetch FIFO, word unpacker, SCALE replication.
// Define VGA_FB_READER_UNDERRUN_EN for underrun colour substitution and the sticky flag.
module vga_fb_reader #(
  parameter int RAM_WIDTH   = 32,
  parameter int PIXEL_BITS  = 8,
  parameter int H_PIX       = 480,
  parameter int V_PIX       = 360,
  parameter int SCALE       = 1,
  parameter int RAM_LATENCY = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter logic [PIXEL_BITS-1:0] UNDERRUN_COLOR = '0
) (
  input logic clk,
  input logic rst,
  vga_fb_reader_if.master bus
);
  localparam int PPW    = RAM_WIDTH / PIXEL_BITS;
  localparam int WPL    = H_PIX / PPW;
  localparam int WORDS  = WPL * V_PIX;
  localparam int ADDR_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int WCW    = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int LCW    = (V_PIX > 1) ? $clog2(V_PIX) : 1;
  localparam int RCW    = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int PIW    = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int CW     = $clog2(FIFO_DEPTH) + 2;

  if ((RAM_WIDTH % PIXEL_BITS) != 0 || (H_PIX % PPW) != 0 || SCALE < 1 ||
      RAM_LATENCY < 1 || RAM_LATENCY > 4 || FIFO_DEPTH < RAM_LATENCY + 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || $bits(UNDERRUN_COLOR) != PIXEL_BITS) begin : g_bad_cfg
    $error("vga_fb_reader: illegal parameter combination");
  end

  typedef enum logic [1:0] {FILL, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic                   issue, last_word, push, pop, consume, empty;
  logic [RAM_LATENCY:0]   vld_pipe;
  logic [ADDR_W-1:0]      addr, base, rd_addr_q;
  logic [WCW-1:0]         wcnt;
  logic [LCW-1:0]         line;
  logic [RCW-1:0]         rep, prep;
  logic [PIW-1:0]         pix_idx;
  logic [CW-1:0]          count, pending;
  logic [PW-1:0]          wp, rp;
  logic [RAM_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [RAM_WIDTH-1:0]   head;
  logic [PIXEL_BITS-1:0]  cur_pix, pixel_q;
  logic                   pixel_valid_q;

  assign last_word = (wcnt == WCW'(WPL - 1)) && (rep == RCW'(SCALE - 1)) &&
                     (line == LCW'(V_PIX - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  // pending counts decided-but-not-yet-pushed words, so the FIFO can never overflow
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    if (bus.frame_start) begin
      state_nxt = FILL;
    end else begin
      issue = (state != DONE) && (count + pending < CW'(FIFO_DEPTH));
      case (state)
        FILL:    if (issue && last_word) state_nxt = DONE;
                 else if (!empty)        state_nxt = RUN;
        RUN:     if (issue && last_word) state_nxt = DONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.frame_start) begin
      addr      <= '0;
      base      <= '0;
      wcnt      <= '0;
      line      <= '0;
      rep       <= '0;
      rd_addr_q <= '0;
      vld_pipe  <= '0;
      pending   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[RAM_LATENCY-1:0], issue};
      pending  <= pending + CW'(issue) - CW'(push);
      if (issue) begin
        rd_addr_q <= addr;
        if (wcnt == WCW'(WPL - 1)) begin
          wcnt <= '0;
          if (rep != RCW'(SCALE - 1)) begin
            rep  <= rep + 1'b1;
            addr <= base;
          end else begin
            rep  <= '0;
            line <= line + 1'b1;
            base <= base + ADDR_W'(WPL);
            addr <= addr + 1'b1;
          end
        end else begin
          wcnt <= wcnt + 1'b1;
          addr <= addr + 1'b1;
        end
      end
    end
  end

  assign bus.rd_en   = vld_pipe[0];
  assign bus.rd_addr = rd_addr_q;

  assign push  = vld_pipe[RAM_LATENCY];
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= bus.rd_data;
  end

  always_ff @(posedge clk) begin
    if (rst || bus.frame_start) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign consume = bus.visible && !bus.frame_start && !empty;
  assign head    = mem[rp];
  assign cur_pix = head[int'(pix_idx) * PIXEL_BITS +: PIXEL_BITS];
  assign pop     = consume && (pix_idx == PIW'(PPW - 1)) && (prep == RCW'(SCALE - 1));

  always_ff @(posedge clk) begin
    if (rst || bus.frame_start) begin
      pix_idx <= '0;
      prep    <= '0;
    end else if (consume) begin
      if (prep == RCW'(SCALE - 1)) begin
        prep    <= '0;
        pix_idx <= (pix_idx == PIW'(PPW - 1)) ? '0 : pix_idx + 1'b1;
      end else begin
        prep <= prep + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.frame_start || !bus.visible) begin
      pixel_q       <= '0;
      pixel_valid_q <= 1'b0;
    end else if (!empty) begin
      pixel_q       <= cur_pix;
      pixel_valid_q <= 1'b1;
    end else begin
`ifdef VGA_FB_READER_UNDERRUN_EN
      pixel_q       <= UNDERRUN_COLOR;
`endif
      pixel_valid_q <= 1'b1;
    end
  end

  assign bus.pixel       = pixel_q;
  assign bus.pixel_valid = pixel_valid_q;

`ifdef VGA_FB_READER_UNDERRUN_EN
  logic underrun_q;
  always_ff @(posedge clk) begin
    if (rst || bus.frame_start)  underrun_q <= 1'b0;
    else if (bus.visible && empty) underrun_q <= 1'b1;
  end
  assign bus.underrun = underrun_q;
`else
  assign bus.underrun = 1'b0;
`endif

endmodule

// File: tb/tb_vga_fb_reader.sv
// Directed bench for vga_fb_reader: base, SCALE=2 and RAM_LATENCY=3 instances.
module tb_vga_fb_reader;
  logic clk, rst;
  logic [2:0] vis, fs;
  logic [7:0] pix [3];
  logic       pv [3], und [3], ren [3];
  logic [2:0] radr [3];
  logic [31:0] r0, r1, r2a, r2b, r2c;

  int checks = 0, failures = 0;
  int sel = 0, iss = 0, pvc = 0, maxout = 0;
  int aq [$];

  vga_fb_reader_if #(.ADDR_W(3)) b0 ();
  vga_fb_reader_if #(.ADDR_W(3)) b1 ();
  vga_fb_reader_if #(.ADDR_W(3)) b2 ();

  vga_fb_reader #(.H_PIX(8), .V_PIX(4), .SCALE(1), .RAM_LATENCY(1), .FIFO_DEPTH(4),
                  .UNDERRUN_COLOR(8'hEE)) u0 (.clk(clk), .rst(rst), .bus(b0));
  vga_fb_reader #(.H_PIX(8), .V_PIX(4), .SCALE(2), .RAM_LATENCY(1), .FIFO_DEPTH(4),
                  .UNDERRUN_COLOR(8'hEE)) u1 (.clk(clk), .rst(rst), .bus(b1));
  vga_fb_reader #(.H_PIX(8), .V_PIX(4), .SCALE(1), .RAM_LATENCY(3), .FIFO_DEPTH(8),
                  .UNDERRUN_COLOR(8'hEE)) u2 (.clk(clk), .rst(rst), .bus(b2));

  function automatic logic [31:0] ramw(input logic [2:0] a);
    logic [7:0] b;
    b = 8'(a);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  always @(posedge clk) begin
    r0  <= ramw(b0.rd_addr);
    r1  <= ramw(b1.rd_addr);
    r2a <= ramw(b2.rd_addr);
    r2b <= r2a;
    r2c <= r2b;
  end

  assign b0.rd_data = r0;
  assign b1.rd_data = r1;
  assign b2.rd_data = r2c;
  assign b0.visible = vis[0];  assign b0.frame_start = fs[0];
  assign b1.visible = vis[1];  assign b1.frame_start = fs[1];
  assign b2.visible = vis[2];  assign b2.frame_start = fs[2];
  assign pix[0] = b0.pixel;  assign pv[0] = b0.pixel_valid;  assign und[0] = b0.underrun;
  assign pix[1] = b1.pixel;  assign pv[1] = b1.pixel_valid;  assign und[1] = b1.underrun;
  assign pix[2] = b2.pixel;  assign pv[2] = b2.pixel_valid;  assign und[2] = b2.underrun;
  assign ren[0] = b0.rd_en;  assign radr[0] = b0.rd_addr;
  assign ren[1] = b1.rd_en;  assign radr[1] = b1.rd_addr;
  assign ren[2] = b2.rd_en;  assign radr[2] = b2.rd_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // issued-address log and outstanding-word tracker for the selected instance
  always @(negedge clk) begin
    if (rst || fs[sel]) begin
      aq.delete();
      iss = 0; pvc = 0; maxout = 0;
    end else begin
      if (ren[sel]) begin aq.push_back(int'(radr[sel])); iss++; end
      if (pv[sel]) pvc++;
      if (iss - pvc / 4 > maxout) maxout = iss - pvc / 4;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic int aq_at(input int i);
    return (i < aq.size()) ? aq[i] : -1;
  endfunction

  task automatic start_frame(input int d, input int prime);
    sel = d;
    vis = '0;
    fs[d] = 1'b1; tick(); fs[d] = 1'b0;
    repeat (prime) tick();
  endtask

  // whole frame: output line l, column x shows source line l/scale, pixel x/scale
  task automatic frame(input int d, input int scale, input int prime);
    int s, px;
    start_frame(d, prime);
    for (int l = 0; l < 4 * scale; l++) begin
      for (int x = 0; x < 8 * scale; x++) begin
        s = l / scale; px = x / scale;
        vis[d] = 1'b1; tick();
        chk($sformatf("pix d%0d l%0d x%0d", d, l, x), {pv[d], pix[d]},
            {1'b1, 8'(s * 2 + px / 4 + px % 4)});
      end
      vis[d] = 1'b0; tick();
      chk($sformatf("blank d%0d l%0d", d, l), {pv[d], pix[d]}, 9'h0);
      repeat (3) tick();
    end
    chk($sformatf("done_rd_en d%0d", d), ren[d], 1'b0);
    chk($sformatf("no_underrun d%0d", d), und[d], 1'b0);
  endtask

  initial begin
    rst = 1'b1; vis = '0; fs = '0;
    repeat (3) tick();
    for (int d = 0; d < 3; d++)
      chk($sformatf("reset d%0d", d), {ren[d], radr[d], und[d], pv[d], pix[d]}, 13'h0);
    rst = 1'b0;
    repeat (4) tick();

    // base configuration: addresses 0..7 once each
    frame(0, 1, 8);
    chk("addr_cnt d0", aq.size(), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("addr d0 #%0d", i), aq_at(i), i);

    // SCALE=2: each source line fetched twice
    frame(1, 2, 8);
    chk("addr_cnt d1", aq.size(), 16);
    for (int i = 0; i < 16; i++) chk($sformatf("addr d1 #%0d", i), aq_at(i), (i / 4) * 2 + i % 2);

    // RAM_LATENCY=3, FIFO_DEPTH=8
    frame(2, 1, 16);
    chk("addr_cnt d2", aq.size(), 8);
    chk("outstanding d2", maxout <= 8, 1'b1);

    // frame_start mid-line, asserted together with visible
    start_frame(0, 8);
    for (int x = 0; x < 5; x++) begin
      vis[0] = 1'b1; tick();
      chk($sformatf("pre_fs x%0d", x), pix[0], 8'(x / 4 + x % 4));
    end
    fs[0] = 1'b1; tick(); fs[0] = 1'b0;
    chk("fs_wins", {pv[0], pix[0]}, 9'h0);
    vis[0] = 1'b0;
    repeat (8) tick();
    for (int x = 0; x < 4; x++) begin
      vis[0] = 1'b1; tick();
      chk($sformatf("post_fs x%0d", x), {pv[0], pix[0]}, {1'b1, 8'(x)});
    end
    vis[0] = 1'b0; tick();

    // visible one cycle after frame_start: FIFO still empty
    start_frame(0, 0);
    vis[0] = 1'b1; tick(); vis[0] = 1'b0;
`ifdef VGA_FB_READER_UNDERRUN_EN
    chk("underrun_pix", {pv[0], pix[0]}, {1'b1, 8'hEE});
    chk("underrun_set", und[0], 1'b1);
    repeat (8) tick();
    chk("underrun_hold", und[0], 1'b1);
`else
    chk("underrun_pix", {pv[0], pix[0]}, {1'b1, 8'h00});
    chk("underrun_set", und[0], 1'b0);
    repeat (8) tick();
    chk("underrun_hold", und[0], 1'b0);
`endif
    vis[0] = 1'b1; tick(); vis[0] = 1'b0;
    chk("after_underrun", {pv[0], pix[0]}, {1'b1, 8'h00});
    fs[0] = 1'b1; tick(); fs[0] = 1'b0;
    chk("underrun_clr", und[0], 1'b0);

    // synchronous reset mid-frame
    start_frame(0, 8);
    for (int x = 0; x < 6; x++) begin vis[0] = 1'b1; tick(); end
    rst = 1'b1; tick(); rst = 1'b0; vis[0] = 1'b0;
    chk("rst_outputs", {ren[0], radr[0], und[0], pv[0], pix[0]}, 13'h0);
    repeat (4) tick();
    chk("rst_restart_addr", aq_at(0), 0);
    chk("rst_restart_cnt", aq.size() > 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_fb_reader.md
# vga_fb_reader

Parametrised framebuffer-to-VGA pixel streamer, the next generation of the team's single-word RAM reader. It fetches packed words from a synchronous framebuffer RAM with configurable read latency and buffers them in a small prefetch FIFO. It unpacks several pixels per word and applies integer pixel/line replication (SCALE) so that a low-resolution buffer fills the display. It sits between the framebuffer BRAM read port and the VGA colour output stage, driven by the timing generator's `visible` and `frame_start`.

## Interface
- `RAM_WIDTH`, 32, bits per RAM word.
- `PIXEL_BITS`, 8, bits per pixel. RAM_WIDTH % PIXEL_BITS == 0 (elaboration error otherwise).
- `H_PIX`, 480, source pixels per line. H_PIX % (RAM_WIDTH/PIXEL_BITS) == 0.
- `V_PIX`, 360, source lines per frame.
- `SCALE`, 1, replication factor (≥1) on both axes.
- `RAM_LATENCY`, 1, cycles from `rd_en` to `rd_data` valid (1..4).
- `FIFO_DEPTH`, 4, prefetch FIFO words (power of 2, ≥ RAM_LATENCY+2).
- `UNDERRUN_COLOR`, 0, pixel value substituted on underrun.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `visible`  in  1  display is in the active region this cycle; one pixel is consumed per visible cycle.
- `frame_start`  in  1  single-cycle pulse during vertical blanking; restarts the frame.
- `rd_addr`  out  $clog2(H_PIX*V_PIX*PIXEL_BITS/RAM_WIDTH)  framebuffer word address.
- `rd_en`  out  1  read request.
- `rd_data`  in  RAM_WIDTH  read data, valid RAM_LATENCY cycles after `rd_en`.
- `pixel`  out  PIXEL_BITS  output colour.
- `pixel_valid`  out  1  `pixel` corresponds to a visible cycle.
- `underrun`  out  1  sticky underrun flag (see Configuration).

## Operation
- Derived values: PPW = RAM_WIDTH/PIXEL_BITS; WPL = H_PIX/PPW words per line; WORDS = WPL*V_PIX.
- Fetch FSM:
  - FILL/RUN: issues `rd_en` whenever FIFO occupancy + in-flight reads < FIFO_DEPTH.
  - DONE: `rd_en` stays 0 once the last word of the last line's last repeat has been issued.
- Fetch addressing: `rd_addr` advances by 1 per issued read. At the end of a line (WPL words), if the line's repeat count < SCALE-1, the address rewinds to the line base and the repeat count increments. Otherwise the repeat count clears and fetching continues with the next line. After line V_PIX-1 the FSM enters DONE; there is no wrap to 0 until `frame_start`.
- Returned words are pushed into the FIFO through a RAM_LATENCY-deep valid shift register.
- Unpacker: the pixel index within the word advances every SCALE visible cycles. Pixels are taken LSB-first: pixel k = word[k*PIXEL_BITS +: PIXEL_BITS]. The FIFO pops when pixel PPW-1 finishes its SCALE repeats.
- Not visible: `pixel`=0, `pixel_valid`=0, and no consumption.
- `frame_start`: FIFO flushed, in-flight returns discarded (shift register cleared), fetch address, line and repeat counters zeroed, unpacker index zeroed, FSM→FILL.
- `frame_start` together with `visible`: `frame_start` wins; no pixel is consumed and the output is 0.

## Timing
- Reset values: `rd_addr`=0, `rd_en`=0, `pixel`=0, `pixel_valid`=0, `underrun`=0. FIFO is empty and the FSM is in FILL, so prefetch starts from address 0 on the first cycle after reset.
- `rst` mid-frame behaves exactly as reset. Pixels stay unpaced until the next `frame_start`.
- Output latency: `pixel`/`pixel_valid` are registered, 1 cycle after the `visible` cycle that consumed them.
- Prime time: the first pixel is available FIFO_DEPTH + RAM_LATENCY + 1 cycles after `frame_start`. The timing generator guarantees at least this much blanking.
- Sustained consumption is ≤ 1 word per PPW*SCALE visible cycles; fetch capacity is 1 word/cycle.
- Underrun: a visible cycle with the FIFO empty.

## Configuration
- `VGA_FB_READER_UNDERRUN_EN` defined:
  - On underrun, `pixel`=UNDERRUN_COLOR and `pixel_valid`=1.
  - `underrun` sets and holds until `rst` or `frame_start`.
  - The unpacker index does not advance on an underrun cycle.
- Undefined: `underrun` tied 0 and no underrun detection logic is generated. On an empty FIFO, `pixel` repeats the last output value.

## Test plan
Bench parameters unless noted: RAM_WIDTH=32, PIXEL_BITS=8, H_PIX=8, V_PIX=4, SCALE=1, RAM_LATENCY=1. RAM model: word[a] = {a,a,a,a}+{3,2,1,0}.
- Reset, then `frame_start`, then 8 visible cycles per line over 4 lines -> pixel stream 0,1,2,3,1,2,3,4,…; `rd_addr` runs 0..7, then `rd_en`=0 (DONE); `underrun`=0.
- SCALE=2, 16 visible cycles per line over 8 lines -> each pixel repeated 2 cycles; each source line emitted twice; `rd_addr` per line runs 0,1,0,1 then 2,3,2,3.
- RAM_LATENCY=3, FIFO_DEPTH=8 -> output identical to the first scenario; `rd_en` never exceeds 8 outstanding words.
- `frame_start` pulsed mid-line (after 5 pixels) -> FIFO flushed; the next visible cycle after priming outputs pixel 0 of word 0; stale in-flight data never appears.
- With `VGA_FB_READER_UNDERRUN_EN`, `visible` asserted 1 cycle after `frame_start` -> `pixel`=UNDERRUN_COLOR, `underrun`=1 until the next `frame_start`; without the macro, `underrun`=0.
- `rst` asserted for 1 cycle mid-frame -> all outputs 0 on the next cycle; `rd_addr` restarts at 0.
